// File: rtl/jk_drive_sequencer.sv
// Modulo-MOD up/down counter that keeps its state in JK form and drives the J/K
// excitation of an external JK register bank, checking the bank's fed-back state.
module jk_drive_sequencer #(
    parameter int WIDTH = 4,
    parameter int MOD   = 10
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             en,
    input  logic             up,
    input  logic             ld_valid,
    output logic             ld_ready,
    input  logic [WIDTH-1:0] ld_data,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             range_err,
    output logic             err,
    output logic             err_sticky
);

    typedef enum logic [1:0] {SYNC, RUN, SETTLE} state_t;

    // One extra bit so MOD = 2^WIDTH is representable in the range compare.
    localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MOD);
    localparam logic [WIDTH-1:0] Q_MAX = WIDTH'(MOD - 1);

    state_t           state;
    logic             load;
    logic             ld_in_range;
    logic             at_top;
    logic             at_bottom;
    logic [WIDTH-1:0] nxt;

    assign load        = (state == RUN) & ld_valid;
    assign ld_in_range = {1'b0, ld_data} < MOD_W;
    assign at_top      = (q == Q_MAX);
    assign at_bottom   = (q == '0);

    always_comb begin
        nxt = q;
        if (state == RUN) begin
            if (load) begin
                nxt = ld_in_range ? ld_data : '0;
            end else if (en) begin
                if (up) begin
                    nxt = at_top ? '0 : q + 1'b1;
                end else begin
                    nxt = at_bottom ? Q_MAX : q - 1'b1;
                end
            end
        end
    end

    assign j  = ~q & nxt;
    assign k  = q & ~nxt;
    assign tc = (state == RUN) & en & ~ld_valid & ((up & at_top) | (~up & at_bottom));

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state      <= SYNC;
            ld_ready   <= 1'b0;
            q          <= '0;
            range_err  <= 1'b0;
            err        <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            // Same JK characteristic equation as the external bank.
            q          <= (j & ~q) | (~k & q);
            range_err  <= load & ~ld_in_range;
            err        <= (state != SYNC) & (q_fb != q);
            err_sticky <= err_sticky | err;
            case (state)
                SYNC: begin
                    state    <= RUN;
                    ld_ready <= 1'b1;
                end
                RUN: begin
                    if (load) begin
                        state    <= SETTLE;
                        ld_ready <= 1'b0;
                    end
                end
                SETTLE: begin
                    state    <= RUN;
                    ld_ready <= 1'b1;
                end
                default: begin
                    state    <= SYNC;
                    ld_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jk_drive_sequencer.sv
// Scoreboard bench for jk_drive_sequencer: a behavioural model queues the expected
// outputs for each cycle and an independent monitor compares them at the falling edge.
module tb_jk_drive_sequencer;

    localparam int WIDTH = 4;
    localparam int MOD   = 10;

    logic             clk = 1'b0;
    logic             clrn = 1'b0;
    logic             en = 1'b0;
    logic             up = 1'b1;
    logic             ld_valid = 1'b0;
    logic [WIDTH-1:0] ld_data = '0;
    logic [WIDTH-1:0] inj = '0;
    logic [WIDTH-1:0] q_fb;
    logic             ld_ready;
    logic [WIDTH-1:0] j, k, q;
    logic             tc, range_err, err, err_sticky;

    logic [WIDTH-1:0] bank;

    jk_drive_sequencer #(.WIDTH(WIDTH), .MOD(MOD)) dut (
        .clk(clk), .clrn(clrn), .en(en), .up(up),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
        .q_fb(q_fb), .j(j), .k(k), .q(q), .tc(tc),
        .range_err(range_err), .err(err), .err_sticky(err_sticky)
    );

    always #5 clk = ~clk;

    // External JK bank on the same clock and reset; inj corrupts its feedback.
    always @(posedge clk or negedge clrn) begin
        if (!clrn) bank <= '0;
        else       bank <= (j & ~bank) | (~k & bank);
    end
    assign q_fb = bank ^ inj;

    typedef struct {
        int q; int j; int k; int tc; int ldr; int rerr; int err; int stk;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Model: mode 0 = waiting after reset, 1 = counting, 2 = post-load settle
    int m_mode = 0;
    int m_q    = 0;
    int m_err  = 0;
    int m_stk  = 0;
    int m_rerr = 0;

    function automatic int model_next();
        if (m_mode == 1 && ld_valid) return (int'(ld_data) < MOD) ? int'(ld_data) : 0;
        if (m_mode == 1 && en)       return up ? (m_q + 1) % MOD : (m_q + MOD - 1) % MOD;
        return m_q;
    endfunction

    function automatic exp_t model_expect();
        exp_t e;
        int   n;
        n      = model_next();
        e.q    = m_q;
        e.j    = ~m_q & n & ((1 << WIDTH) - 1);
        e.k    = m_q & ~n & ((1 << WIDTH) - 1);
        e.tc   = (m_mode == 1 && en && !ld_valid &&
                  ((up && m_q == MOD - 1) || (!up && m_q == 0))) ? 1 : 0;
        e.ldr  = (m_mode == 1) ? 1 : 0;
        e.rerr = m_rerr;
        e.err  = m_err;
        e.stk  = m_stk;
        return e;
    endfunction

    task automatic model_edge();
        int n;
        n      = model_next();
        m_stk  = m_stk | m_err;
        m_err  = (m_mode != 0 && inj != 0) ? 1 : 0;
        m_rerr = (m_mode == 1 && ld_valid && int'(ld_data) >= MOD) ? 1 : 0;
        if (m_mode == 1 && ld_valid) m_mode = 2;
        else                         m_mode = 1;
        m_q = n;
    endtask

    task automatic model_reset();
        m_mode = 0; m_q = 0; m_err = 0; m_stk = 0; m_rerr = 0;
    endtask

    // One clock: account for the edge just taken, then apply new stimulus.
    task automatic cyc(input logic rst, input logic e, input logic u, input logic lv,
                       input logic [WIDTH-1:0] ld, input logic [WIDTH-1:0] fi);
        @(posedge clk);
        #2;
        if (clrn) model_edge();
        clrn = ~rst;
        if (rst) model_reset();
        en = e; up = u; ld_valid = lv; ld_data = ld; inj = fi;
        #0;
        sb.push_back(model_expect());
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("q",          int'(q),          e.q);
                chk("j",          int'(j),          e.j);
                chk("k",          int'(k),          e.k);
                chk("tc",         int'(tc),         e.tc);
                chk("ld_ready",   int'(ld_ready),   e.ldr);
                chk("range_err",  int'(range_err),  e.rerr);
                chk("err",        int'(err),        e.err);
                chk("err_sticky", int'(err_sticky), e.stk);
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : driver
        logic       r, e, u, lv;
        logic [3:0] ld, fi;
        // Reset, then release with en high; first edge only syncs.
        cyc(1, 0, 1, 0, 0, 0);
        cyc(1, 0, 1, 0, 0, 0);
        cyc(0, 1, 1, 0, 0, 0);
        // Up count through the wrap.
        repeat (14) cyc(0, 1, 1, 0, 0, 0);
        // Load 7 then reset mid-count.
        cyc(0, 1, 1, 1, 4'd7, 0);
        cyc(0, 1, 1, 0, 0, 0);
        cyc(0, 1, 1, 0, 0, 0);
        cyc(1, 1, 1, 0, 0, 0);
        cyc(0, 1, 1, 0, 0, 4'd1);   // feedback wrong while syncing: must not flag
        repeat (3) cyc(0, 1, 1, 0, 0, 0);
        // Down wrap from 1.
        cyc(0, 0, 0, 1, 4'd1, 0);
        cyc(0, 0, 0, 0, 0, 0);
        repeat (4) cyc(0, 1, 0, 0, 0, 0);
        // Load 3, then load 6 with en high: load wins.
        cyc(0, 0, 1, 1, 4'd3, 0);
        cyc(0, 0, 1, 0, 0, 0);
        cyc(0, 1, 1, 1, 4'd6, 0);
        repeat (3) cyc(0, 1, 1, 0, 0, 0);
        // Out-of-range load.
        cyc(0, 1, 1, 1, 4'd12, 0);
        repeat (3) cyc(0, 1, 1, 0, 0, 0);
        // Feedback fault for one cycle in RUN.
        cyc(0, 1, 1, 0, 0, 4'd1);
        repeat (4) cyc(0, 1, 1, 0, 0, 0);
        // Load held across SETTLE.
        repeat (3) cyc(0, 1, 1, 1, 4'd4, 0);
        repeat (2) cyc(0, 1, 1, 0, 0, 0);
        cyc(1, 0, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);
        // Randomized traffic.
        for (int i = 0; i < 500; i++) begin
            r  = ($urandom_range(0, 99) == 0);
            e  = ($urandom_range(0, 9) < 8);
            u  = 1'($urandom_range(0, 1));
            lv = ($urandom_range(0, 7) == 0);
            ld = 4'($urandom_range(0, 15));
            fi = ($urandom_range(0, 19) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'd0;
            cyc(r, e, u, lv, ld, fi);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/jk_drive_sequencer.md
# jk_drive_sequencer

Modulo-MOD up/down counter whose state is held in JK flip-flop form. Each cycle it computes the J/K excitation vector that moves the current state to the required next state. It also exports that vector to drive an external bank of asynchronous-clear JK flip-flops on the same clock and reset, and checks the bank's fed-back state against its own state every cycle. It sits between control logic and discrete JK register banks, as the excitation/driver side of the JK flip-flop interface.

## Interface
- WIDTH, 4, state width in bits
- MOD, 10, count modulus; legal range 2 ≤ MOD ≤ 2^WIDTH; state range 0..MOD-1
- clk  in  1  clock, rising edge
- clrn  in  1  reset, asynchronous, active-low
- en  in  1  count enable, sampled only in RUN
- up  in  1  direction: 1 = up, 0 = down
- ld_valid  in  1  load request
- ld_ready  out  1  load accept; a load transfers on a rising edge with ld_valid & ld_ready
- ld_data  in  WIDTH  load value
- q_fb  in  WIDTH  state fed back from the external JK bank
- j  out  WIDTH  J excitation, combinational
- k  out  WIDTH  K excitation, combinational
- q  out  WIDTH  internal state
- tc  out  1  terminal count, combinational; high when the next edge wraps
- range_err  out  1  one-cycle pulse: an accepted load value was ≥ MOD
- err  out  1  registered mismatch flag: high for the cycle after q_fb ≠ q was sampled
- err_sticky  out  1  set by any err; cleared only by clrn

## Operation
- **FSM states:** SYNC, RUN, SETTLE.
  - clrn low forces SYNC.
  - SYNC → RUN after one clock edge.
  - RUN → SETTLE on an accepted load.
  - SETTLE → RUN after one edge.
- **Next state nxt:**
  - SYNC or SETTLE: nxt = q (hold).
  - RUN with an accepted load: nxt = ld_data if ld_data < MOD, else 0.
  - RUN, en=1, up=1: nxt = MOD-1 → 0 wrap, else q+1.
  - RUN, en=1, up=0: nxt = 0 → MOD-1 wrap, else q-1.
  - RUN, en=0: nxt = q.
  - Priority: load > count > hold.
- **Excitation per bit:** j = ~q & nxt, k = q & ~nxt. Hold gives j = k = 0. The toggle case (j = k = 1) is never produced.
- **Internal update:** q <= j & ~q | ~k & q, which equals nxt.
- **ld_ready:** 1 only in RUN.
- **tc:** RUN & en & ~load & ((up & q == MOD-1) | (~up & q == 0)).
- **range_err:** registered; pulses in the cycle after an accepted load with ld_data ≥ MOD.
- **Checker:** in RUN and SETTLE, sample (q_fb ≠ q) each edge into err. Checking is masked in SYNC. err_sticky <= err_sticky | err.

## Timing
- **Reset values:**
  - q = 0, state SYNC, ld_ready = 0.
  - j = k = 0.
  - tc = 0, range_err = 0, err = 0, err_sticky = 0.
- **Release:** first edge after clrn rises: SYNC → RUN. Counting and loads begin on the second edge.
- **Count latency:** q reflects a count on the same edge that samples en.
- **Load latency:**
  - Load accepted at edge N: q = ld_data after edge N.
  - ld_ready = 0 and en is ignored through edge N+1.
  - RUN resumes after edge N+1.
  - ld_valid held high across SETTLE reloads at edge N+2.
- **Simultaneous events:** load and en in the same RUN cycle: load wins, no count, tc = 0.
- **Wrap:** up at MOD-1 gives 0; down at 0 gives MOD-1. tc is high in the cycle before the wrapping edge.
- **MOD = 2^WIDTH:** wrap is natural overflow. range_err can never fire.
- **Checker latency:** a mismatch present at edge E shows as err after E. err_sticky is set after E+1.
- **Reset mid-operation:** clrn low asynchronously clears q, err, err_sticky and the FSM, and drops ld_ready. A pending load is discarded.

## Test plan
- **Reset/sync:** assert clrn=0 mid-count at q=7 → q=0, ld_ready=0, j=k=0 immediately. After release, with en=1, up=1, q stays 0 for one edge, then reads 1, 2, ...
- **Up wrap (WIDTH=4, MOD=10):** from q=0, en=1, up=1 for 12 edges → q sequence 1..9, 0, 1, 2. tc=1 only while q=9. At q=9: j=0000, k=1001.
- **Down wrap:** from q=1, en=1, up=0 → q goes 0, then 9. tc=1 while q=0. At q=0: j=1001, k=0000.
- **Load/priority:**
  - ld_valid=1, ld_data=6, en=1 at q=3 → q=6 (no count); ld_ready=0 for one cycle; count resumes to 7.
  - ld_data=12 → q=0, range_err pulses once.
- **Checker:** drive a model JK bank from j/k; force q_fb bit0 wrong for one cycle in RUN → err high exactly one cycle later, err_sticky stays 1 until clrn. No err in SYNC even with q_fb ≠ q.
- **Handshake backpressure:** ld_valid held high for 3 cycles with data 4 → loads at the first RUN edge and again after SETTLE. q=4 throughout. No count occurs.
